// File: rtl/i2c_dac_target.sv
// I2C target with a single 16-bit register, answering the DAC101C081-style
// write/read protocol. SCL/SDA are oversampled and filtered on Clock; SDA is open-drain via SDAen.
//
// state   | meaning
// S_IDLE  | bus free, waiting for START
// S_ADDR  | shifting in the address byte
// S_ACK_A | driving ACK for a matched address
// S_WR_HI | receiving the high data byte (or an excess byte once the register was written)
// S_ACK_W1| driving ACK for the high byte
// S_WR_LO | receiving the low data byte
// S_ACK_W2| driving ACK for the low byte
// S_RD_HI | driving RegQ[15:8]
// S_MACK1 | sampling master ACK after the high byte
// S_RD_LO | driving RegQ[7:0]
// S_MACK2 | master ACK/NACK after the low byte
// S_IGNORE| SDA released, waiting for STOP or START
module i2c_dac_target #(
  parameter logic [6:0]  DEV_ADDR = 7'b0001100,
  parameter int          FILT     = 3,
  parameter logic [15:0] RST_VAL  = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCLin,
  input  logic        SDAin,
  output logic        SDAen,
  output logic [15:0] RegQ,
  output logic        WrStrobe,
  output logic        RdStrobe,
  output logic        Busy,
  output logic [1:0]  Error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_WR_HI, S_ACK_W1, S_WR_LO,
    S_ACK_W2, S_RD_HI, S_MACK1, S_RD_LO, S_MACK2, S_IGNORE
  } state_t;

  localparam logic [2:0] FILT_TC = 3'(FILT - 1);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_tmr, sda_tmr;
  logic       scl_f, sda_f, scl_d, sda_d;

  // Filter timers count down while the synced level disagrees; terminal count accepts it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_tmr  <= FILT_TC;
      sda_tmr  <= FILT_TC;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCLin};
      sda_sync <= {sda_sync[0], SDAin};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_tmr <= FILT_TC;
      end else if (scl_tmr == 3'd0) begin
        scl_f   <= scl_sync[1];
        scl_tmr <= FILT_TC;
      end else begin
        scl_tmr <= scl_tmr - 3'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_tmr <= FILT_TC;
      end else if (sda_tmr == 3'd0) begin
        sda_f   <= sda_sync[1];
        sda_tmr <= FILT_TC;
      end else begin
        sda_tmr <= sda_tmr - 3'd1;
      end
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, scl_edge, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign sda_rise  = sda_f & ~sda_d;
  assign sda_fall  = ~sda_f & sda_d;
  assign scl_edge  = scl_rise | scl_fall;
  assign start_det = sda_fall & scl_f & ~scl_edge;
  assign stop_det  = sda_rise & scl_f & ~scl_edge;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        phase, phase_n;
  logic        over, over_n;
  logic [15:0] sh, sh_n;
  logic [15:0] reg_n;
  logic        sda_n, wr_n, rd_n, busy_n;
  logic [1:0]  err_n;
  logic        mid_byte;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      phase    <= 1'b0;
      over     <= 1'b0;
      sh       <= 16'h0000;
      RegQ     <= RST_VAL;
      SDAen    <= 1'b0;
      WrStrobe <= 1'b0;
      RdStrobe <= 1'b0;
      Busy     <= 1'b0;
      Error    <= 2'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      over     <= over_n;
      sh       <= sh_n;
      RegQ     <= reg_n;
      SDAen    <= sda_n;
      WrStrobe <= wr_n;
      RdStrobe <= rd_n;
      Busy     <= busy_n;
      Error    <= err_n;
    end
  end

  // cnt counts completed bit clocks, so a STOP/START in the first bit's high phase is not mid-byte.
  always_comb begin
    mid_byte = 1'b0;
    if ((state == S_ADDR || state == S_WR_HI || state == S_WR_LO ||
         state == S_RD_HI || state == S_RD_LO) && cnt != 3'd0)
      mid_byte = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phase_n = phase;
    over_n  = over;
    sh_n    = sh;
    reg_n   = RegQ;
    sda_n   = SDAen;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    busy_n  = Busy;
    err_n   = Error;

    if (stop_det) begin
      state_n = S_IDLE;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      sda_n   = 1'b0;
      busy_n  = 1'b0;
      if (mid_byte) err_n = 2'd3;
    end else if (start_det) begin
      state_n = S_ADDR;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      over_n  = 1'b0;
      sda_n   = 1'b0;
      busy_n  = 1'b1;
      err_n   = mid_byte ? 2'd3 : 2'd0;
    end else begin
      case (state)
        S_IDLE: ;

        S_ADDR, S_WR_HI, S_WR_LO: begin
          if (scl_rise) begin
            sh_n    = {sh[14:0], sda_f};
            phase_n = 1'b1;
            if (cnt == 3'd7) begin
              cnt_n   = 3'd0;
              phase_n = 1'b0;
              if (state == S_ADDR) begin
                state_n = (sh_n[7:1] == DEV_ADDR) ? S_ACK_A : S_IGNORE;
              end else if (state == S_WR_HI) begin
                if (over) begin
                  err_n   = 2'd1;
                  state_n = S_IGNORE;
                end else begin
                  state_n = S_ACK_W1;
                end
              end else begin
                // shifter now holds {hi, lo}
                reg_n   = sh_n;
                wr_n    = 1'b1;
                over_n  = 1'b1;
                state_n = S_ACK_W2;
              end
            end
          end else if (scl_fall && phase) begin
            cnt_n   = cnt + 3'd1;
            phase_n = 1'b0;
          end
        end

        S_ACK_A, S_ACK_W1, S_ACK_W2: begin
          if (scl_fall) begin
            if (!phase) begin
              phase_n = 1'b1;
              sda_n   = 1'b1;
            end else begin
              phase_n = 1'b0;
              sda_n   = 1'b0;
              cnt_n   = 3'd0;
              if (state == S_ACK_A && sh[0]) begin
                state_n = S_RD_HI;
                sh_n    = RegQ;
                rd_n    = 1'b1;
                sda_n   = ~RegQ[15];
              end else if (state == S_ACK_W1) begin
                state_n = S_WR_LO;
              end else begin
                state_n = S_WR_HI;
              end
            end
          end
        end

        S_RD_HI, S_RD_LO: begin
          if (scl_fall) begin
            sh_n = {sh[14:0], 1'b0};
            if (cnt == 3'd7) begin
              cnt_n   = 3'd0;
              phase_n = 1'b0;
              sda_n   = 1'b0;
              state_n = (state == S_RD_HI) ? S_MACK1 : S_MACK2;
            end else begin
              cnt_n = cnt + 3'd1;
              sda_n = ~sh_n[15];
            end
          end
        end

        S_MACK1: begin
          if (scl_rise) begin
            if (sda_f) begin
              err_n   = 2'd2;
              state_n = S_IGNORE;
            end else begin
              phase_n = 1'b1;
            end
          end else if (scl_fall && phase) begin
            phase_n = 1'b0;
            cnt_n   = 3'd0;
            sda_n   = ~sh[15];
            state_n = S_RD_LO;
          end
        end

        S_MACK2: begin
          if (scl_rise) state_n = S_IGNORE;
        end

        S_IGNORE: sda_n = 1'b0;

        default: begin
          state_n = S_IDLE;
          sda_n   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_dac_target.sv
// Bench for i2c_dac_target: bit-banged I2C master with wired-AND SDA, table-driven
// write vectors, hand sequences for glitches/reset, and randomized transactions vs a register model.
module tb_i2c_dac_target;
  localparam int         Q   = 12;
  localparam logic [6:0] DEV = 7'h0C;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        SCLin = 1'b1;
  logic        sda_m = 1'b1;
  logic        SDAin;
  logic        SDAen, WrStrobe, RdStrobe, Busy;
  logic [15:0] RegQ;
  logic [1:0]  Error;

  int   n_cmp = 0, n_bad = 0;
  int   wr_cnt = 0, rd_cnt = 0, sden_cyc = 0, sden_viol = 0;
  logic sden_prev = 1'b0;

  assign SDAin = sda_m & ~SDAen;

  always #5 Clock = ~Clock;

  i2c_dac_target #(.DEV_ADDR(DEV), .FILT(3), .RST_VAL(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .SCLin(SCLin), .SDAin(SDAin), .SDAen(SDAen),
    .RegQ(RegQ), .WrStrobe(WrStrobe), .RdStrobe(RdStrobe), .Busy(Busy), .Error(Error)
  );

  always @(posedge Clock) begin
    if (WrStrobe) wr_cnt <= wr_cnt + 1;
    if (RdStrobe) rd_cnt <= rd_cnt + 1;
    if (SDAen) sden_cyc <= sden_cyc + 1;
    if (!Reset && SCLin && (SDAen !== sden_prev)) sden_viol <= sden_viol + 1;
    sden_prev <= SDAen;
  end

  typedef struct {
    string       name;
    logic [7:0]  addr;
    int          nbytes;
    logic [7:0]  d [3];
    int          tail;
    logic [15:0] exp_reg;
    logic [1:0]  exp_err;
    logic [3:0]  exp_ack;
    int          exp_wr;
  } wvec_t;

  function automatic wvec_t mk(input string n, input logic [7:0] a, input int nb,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                               input int tail, input logic [15:0] r, input logic [1:0] e,
                               input logic [3:0] ack, input int wr);
    wvec_t v;
    v.name = n; v.addr = a; v.nbytes = nb;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.tail = tail; v.exp_reg = r; v.exp_err = e; v.exp_ack = ack; v.exp_wr = wr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sda_m = b;  wait_clk(Q);
    SCLin = 1'b1; wait_clk(Q);
    seen = SDAin; wait_clk(Q);
    SCLin = 1'b0; wait_clk(Q);
  endtask

  task automatic do_start;
    sda_m = 1'b1; wait_clk(Q);
    SCLin = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    SCLin = 1'b0; wait_clk(Q);
  endtask

  task automatic do_stop;
    sda_m = 1'b0; wait_clk(Q);
    SCLin = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mnack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(mnack, s);
  endtask

  task automatic run_write(input wvec_t v);
    int         wr0, sd0;
    logic [3:0] acks;
    logic       a, s;
    logic [7:0] tailpat;
    wr0 = wr_cnt; sd0 = sden_cyc; acks = 4'b0000; tailpat = 8'hF0;
    do_start;
    write_byte(v.addr, a);
    acks[0] = a;
    for (int i = 0; i < v.nbytes; i++) begin
      write_byte(v.d[i], a);
      acks[i+1] = a;
    end
    for (int i = 0; i < v.tail; i++) send_bit(tailpat[7-i], s);
    check({v.name, " busy"}, 32'(Busy), 32'd1);
    do_stop;
    wait_clk(10);
    check({v.name, " acks"}, 32'(acks), 32'(v.exp_ack));
    check({v.name, " regq"}, 32'(RegQ), 32'(v.exp_reg));
    check({v.name, " error"}, 32'(Error), 32'(v.exp_err));
    check({v.name, " wrstrobes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    check({v.name, " idle"}, 32'(Busy), 32'd0);
    if (!v.exp_ack[0]) check({v.name, " sdaen_cycles"}, 32'(sden_cyc - sd0), 32'd0);
  endtask

  task automatic run_read(input string name, input logic [15:0] exp, input logic nack_first);
    int         rd0;
    logic       a;
    logic [7:0] hi, lo;
    rd0 = rd_cnt;
    do_start;
    write_byte({DEV, 1'b1}, a);
    check({name, " addr_ack"}, 32'(a), 32'd1);
    read_byte(nack_first, hi);
    if (!nack_first) read_byte(1'b1, lo);
    do_stop;
    wait_clk(10);
    check({name, " hi"}, 32'(hi), 32'(exp[15:8]));
    if (!nack_first) check({name, " lo"}, 32'(lo), 32'(exp[7:0]));
    check({name, " error"}, 32'(Error), nack_first ? 32'd2 : 32'd0);
    check({name, " rdstrobes"}, 32'(rd_cnt - rd0), 32'd1);
    check({name, " regq"}, 32'(RegQ), 32'(exp));
  endtask

  wvec_t       tbl [7];
  logic [15:0] model_reg;
  logic [6:0]  a7;
  logic [7:0]  d0, d1, d2;
  logic [3:0]  ack;
  logic [1:0]  err;
  logic        a, match;
  int          kind, nb, wr;

  initial begin
    tbl[0] = mk("bad_addr",    8'h1A, 2, 8'h11, 8'h22, 8'h00, 0, 16'h0000, 2'd0, 4'b0000, 0);
    tbl[1] = mk("partial",     8'h18, 1, 8'h12, 8'h00, 8'h00, 4, 16'h0000, 2'd3, 4'b0011, 0);
    tbl[2] = mk("three_bytes", 8'h18, 3, 8'h01, 8'h02, 8'h03, 0, 16'h0102, 2'd1, 4'b0111, 1);
    tbl[3] = mk("one_byte",    8'h18, 1, 8'h77, 8'h00, 8'h00, 0, 16'h0102, 2'd0, 4'b0011, 0);
    tbl[4] = mk("addr_only",   8'h18, 0, 8'h00, 8'h00, 8'h00, 0, 16'h0102, 2'd0, 4'b0001, 0);
    tbl[5] = mk("wr_0ffc",     8'h18, 2, 8'h0F, 8'hFC, 8'h00, 0, 16'h0FFC, 2'd0, 4'b0111, 1);
    tbl[6] = mk("wr_0a5c",     8'h18, 2, 8'h0A, 8'h5C, 8'h00, 0, 16'h0A5C, 2'd0, 4'b0111, 1);

    wait_clk(5);
    check("rst sdaen", 32'(SDAen), 32'd0);
    check("rst regq", 32'(RegQ), 32'h0000);
    check("rst strobes", 32'({WrStrobe, RdStrobe}), 32'd0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst error", 32'(Error), 32'd0);
    Reset = 1'b0;
    wait_clk(20);

    for (int i = 0; i < 7; i++) run_write(tbl[i]);

    run_read("rd_0a5c", 16'h0A5C, 1'b0);
    run_read("rd_nack", 16'h0A5C, 1'b1);

    // 2-clock SDA dip with SCL high must not look like a START
    sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; wait_clk(20);
    check("sda_glitch busy", 32'(Busy), 32'd0);

    // SCL and SDA falling together: SCL edge wins, no START
    sda_m = 1'b0; SCLin = 1'b0; wait_clk(20);
    check("simul_edge busy", 32'(Busy), 32'd0);
    sda_m = 1'b1; SCLin = 1'b1; wait_clk(20);

    // SCL glitch inside a transfer must not add a bit
    do_start;
    SCLin = 1'b1; wait_clk(2); SCLin = 1'b0; wait_clk(Q);
    ack = 4'b0000;
    write_byte(8'h18, a); ack[0] = a;
    write_byte(8'h0F, a); ack[1] = a;
    write_byte(8'hFC, a); ack[2] = a;
    do_stop;
    wait_clk(10);
    check("scl_glitch acks", 32'(ack), 32'h7);
    check("scl_glitch regq", 32'(RegQ), 32'h0FFC);

    // Reset while driving the read high byte (bit15 of 0x0FFC is 0 -> SDA pulled)
    do_start;
    write_byte({DEV, 1'b1}, a);
    check("rdhi sdaen", 32'(SDAen), 32'd1);
    Reset = 1'b1;
    wait_clk(1);
    check("rst_rdhi sdaen", 32'(SDAen), 32'd0);
    check("rst_rdhi regq", 32'(RegQ), 32'h0000);
    check("rst_rdhi busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    wait_clk(10);
    do_stop;
    wait_clk(10);
    model_reg = 16'h0000;

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        run_read("rand_rd", model_reg, ($urandom_range(0, 3) == 0));
      end else begin
        a7 = (kind == 0) ? DEV : 7'($urandom_range(0, 127));
        if (kind == 1 && a7 == DEV) a7 = a7 ^ 7'h01;
        nb = $urandom_range(0, 3);
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        match = (a7 == DEV);
        ack = 4'b0000;
        for (int i = 0; i <= nb; i++) ack[i] = match && (i <= 2);
        wr = (match && nb >= 2) ? 1 : 0;
        if (wr == 1) model_reg = {d0, d1};
        err = (match && nb == 3) ? 2'd1 : 2'd0;
        run_write(mk("rand_wr", {a7, 1'b0}, nb, d0, d1, d2, 0, model_reg, err, ack, wr));
      end
    end

    check("sdaen_changed_with_scl_high", 32'(sden_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
